conv1_layer_scheduler: RTL

//  Sequences the first conv layer (Conv1) over all output channels: loads each 3x3x3 kernel from weight ROM,

---
 rtl/conv1_pkg.sv | 29 ++
 rtl/sched_delay_line.sv | 36 +++
 rtl/conv1_layer_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/conv1_pkg.sv
// rtl/conv1_pkg.sv - Conv1 layer scheduler constants, widths and state encoding
package conv1_pkg;

    localparam int DEF_NUM_CH  = 8;
    localparam int DEF_RAM_LAT = 1;
    localparam int DEF_TIMEOUT = 2047;

    localparam int IMG_SIZE    = 784;
    localparam int OUT_SIZE    = 676;
    localparam int KERNEL_CNT  = 9;

    localparam int WT_AW  = 10;
    localparam int IMG_AW = 10;
    localparam int OFM_AW = 13;
    localparam int OCNT_W = 10;
    localparam int CYC_W  = 12;
    localparam int CH_W   = 4;
    localparam int IDX_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_ARM,
        S_STREAM,
        S_GAP,
        S_FINISH
    } state_t;

endpackage

// File: rtl/sched_delay_line.sv
// rtl/sched_delay_line.sv - resettable DEPTH-stage shift register aligning strobes to RAM read latency
module sched_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv1_layer_scheduler.sv
// rtl/conv1_layer_scheduler.sv - sequences kernel load, arm, image stream and output write for every Conv1 channel
module conv1_layer_scheduler
    import conv1_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int RAM_LAT = DEF_RAM_LAT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wt_rd_en,
    output logic [WT_AW-1:0]  wt_addr,
    input  logic [23:0]       wt_data,
    output logic              kern_we,
    output logic [IDX_W-1:0]  kern_idx,
    output logic [23:0]       kern_data,
    output logic              conv_start,
    output logic              img_rd_en,
    output logic [IMG_AW-1:0] img_addr,
    output logic              image_ready,
    input  logic              conv_ready,
    input  logic              conv_complete,
    input  logic [7:0]        conv_dout,
    output logic              ofm_we,
    output logic [OFM_AW-1:0] ofm_addr,
    output logic [7:0]        ofm_data
);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [IMG_AW-1:0]   addr_q, addr_d;
    logic [OCNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                gap_q, gap_d;
    logic                err_q, err_d;
    logic [IDX_W+1:0]    dl_in, dl_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            out_cnt_q <= '0;
            cyc_q     <= '0;
            gap_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            out_cnt_q <= out_cnt_d;
            cyc_q     <= cyc_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        out_cnt_d  = out_cnt_q;
        cyc_d      = cyc_q;
        gap_d      = gap_q;
        err_d      = err_q;
        done       = 1'b0;
        wt_rd_en   = 1'b0;
        wt_addr    = '0;
        conv_start = 1'b0;
        img_rd_en  = 1'b0;
        img_addr   = '0;
        ofm_we     = 1'b0;
        ofm_addr   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    ch_d    = '0;
                    cnt_d   = '0;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                // Reads occupy the first KERNEL_CNT cycles; the tail lets the last word land.
                if (cnt_q < IDX_W'(KERNEL_CNT)) begin
                    wt_rd_en = 1'b1;
                    wt_addr  = WT_AW'(ch_q) * WT_AW'(KERNEL_CNT) + WT_AW'(cnt_q);
                end
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(KERNEL_CNT + RAM_LAT - 1)) state_d = S_ARM;
            end
            S_ARM: begin
                conv_start = 1'b1;
                addr_d     = '0;
                out_cnt_d  = '0;
                cyc_d      = '0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                img_rd_en = 1'b1;
                img_addr  = addr_q;
                if (addr_q != IMG_AW'(IMG_SIZE - 1)) addr_d = addr_q + IMG_AW'(1);
                cyc_d = cyc_q + CYC_W'(1);
                if (conv_ready) begin
                    if (out_cnt_q < OCNT_W'(OUT_SIZE)) begin
                        ofm_we    = 1'b1;
                        ofm_addr  = OFM_AW'(ch_q) * OFM_AW'(OUT_SIZE) + OFM_AW'(out_cnt_q);
                        out_cnt_d = out_cnt_q + OCNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (conv_complete) begin
                    if (out_cnt_d != OCNT_W'(OUT_SIZE)) err_d = 1'b1;
                    gap_d   = 1'b0;
                    state_d = S_GAP;
                end else if (cyc_q == CYC_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_GAP: begin
                // One idle cycle after image_ready falls lets Conv1 settle back to idle.
                if (!image_ready) begin
                    if (gap_q) begin
                        ch_d    = ch_q + CH_W'(1);
                        cnt_d   = '0;
                        state_d = ((ch_q + CH_W'(1)) < CH_W'(NUM_CH)) ? S_LOAD_W : S_FINISH;
                    end else begin
                        gap_d = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dl_in = {img_rd_en, wt_rd_en, (wt_rd_en ? cnt_q : IDX_W'(0))};

    sched_delay_line #(
        .WIDTH(IDX_W + 2),
        .DEPTH(RAM_LAT)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .din (dl_in),
        .dout(dl_out)
    );

    assign image_ready = dl_out[IDX_W+1];
    assign kern_we     = dl_out[IDX_W];
    assign kern_idx    = dl_out[IDX_W-1:0];
    assign kern_data   = kern_we ? wt_data : 24'h0;
    assign ofm_data    = ofm_we ? conv_dout : 8'h0;
    assign busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign err         = err_q;

endmodule
